// File: rtl/bn_pkg.sv
// ---------------------------------------------------------------------------
// bn_pkg
// Shared types and default constants for the batch-norm gather slice.
// Holds the signed fixed-point sample type, the packed batch vector, the
// fill/count type and a helper that counts full banks.
// Optional build macro used by this slice: BN_GATHER_ZERO_PAD_EN
// ---------------------------------------------------------------------------
package bn_pkg;

  localparam int BN_IL    = 4;
  localparam int BN_FL    = 16;
  localparam int BN_SIZE  = 16;
  localparam int BN_WIDTH = $clog2(BN_SIZE);

  typedef logic signed [BN_IL+BN_FL-1:0] fx_t;
  typedef fx_t [BN_SIZE-1:0]             batch_t;
  typedef logic [BN_WIDTH:0]             cnt_t;

  // Number of full banks out of the two ping-pong banks.
  function automatic logic [1:0] countFull(input logic fullA, input logic fullB);
    return {1'b0, fullA} + {1'b0, fullB};
  endfunction

endpackage

// File: rtl/bn_gather_bank.sv
// ---------------------------------------------------------------------------
// bn_gather_bank
// One ping-pong bank: `size` sample entries plus the num, gamma, beta
// registers and the full flag of the batch it holds.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_wrEn          write i_wrData at entry i_wrIdx
//   i_first         the write is the first sample: capture i_gamma/i_beta
//   i_close         mark bank full and latch i_closeNum as its count
//   i_clear         consumer took the batch: drop the full flag
//   o_entries       all entries, packed
//   o_num/o_gamma/o_beta/o_full  stored batch metadata
// Macro BN_GATHER_ZERO_PAD_EN: clearing also zeroes every entry.
// ---------------------------------------------------------------------------
module bn_gather_bank
  import bn_pkg::*;
#(
  parameter int DW    = BN_IL + BN_FL,
  parameter int size  = BN_SIZE,
  parameter int width = $clog2(size)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_wrEn,
  input  logic [width-1:0]              i_wrIdx,
  input  logic signed [DW-1:0]          i_wrData,
  input  logic                          i_first,
  input  logic signed [DW-1:0]          i_gamma,
  input  logic signed [DW-1:0]          i_beta,
  input  logic                          i_close,
  input  logic [width:0]                i_closeNum,
  input  logic                          i_clear,
  output logic signed [size-1:0][DW-1:0] o_entries,
  output logic [width:0]                o_num,
  output logic signed [DW-1:0]          o_gamma,
  output logic signed [DW-1:0]          o_beta,
  output logic                          o_full
);

  logic signed [size-1:0][DW-1:0] r_entries;
  logic [width:0]                 r_num;
  logic signed [DW-1:0]           r_gamma;
  logic signed [DW-1:0]           r_beta;
  logic                           r_full;

  // Bank storage. A clear only ever targets the read bank, which is full,
  // while a write only targets the write bank, which is not full, so the
  // clear and write paths never hit the same bank in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entries <= '0;
      r_num     <= '0;
      r_gamma   <= '0;
      r_beta    <= '0;
      r_full    <= 1'b0;
    end else begin
      if (i_clear) begin
        r_full <= 1'b0;
`ifdef BN_GATHER_ZERO_PAD_EN
        r_entries <= '0;
`endif
      end
      if (i_wrEn) begin
        r_entries[i_wrIdx] <= i_wrData;
        if (i_first) begin
          r_gamma <= i_gamma;
          r_beta  <= i_beta;
        end
      end
      if (i_close) begin
        r_full <= 1'b1;
        r_num  <= i_closeNum;
      end
    end
  end

  assign o_entries = r_entries;
  assign o_num     = r_num;
  assign o_gamma   = r_gamma;
  assign o_beta    = r_beta;
  assign o_full    = r_full;

endmodule

// File: rtl/bn_batch_gather.sv
// ---------------------------------------------------------------------------
// bn_batch_gather
// Upstream feeder for the batch-norm forward stage. Packs a valid/ready
// sample stream into batches of up to `size` entries in two ping-pong
// banks and presents each batch, with its count and gamma/beta, until the
// consumer takes it.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   in_data/in_valid/in_last/in_ready  sample stream (in_last closes batch)
//   gamma_in, beta_in               captured with the first sample of a batch
//   batch, num, gamma, beta         presented batch (read bank)
//   batch_valid, batch_taken        hold-until-taken handshake
//   pending                         number of full banks (0..2)
// Macro BN_GATHER_ZERO_PAD_EN: taken banks are zeroed, so entries at
// index >= num read 0; otherwise they hold stale data.
// ---------------------------------------------------------------------------
module bn_batch_gather
  import bn_pkg::*;
#(
  parameter int IL    = BN_IL,
  parameter int FL    = BN_FL,
  parameter int size  = BN_SIZE,
  parameter int width = $clog2(size)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [IL+FL-1:0]           in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  input  logic signed [IL+FL-1:0]           gamma_in,
  input  logic signed [IL+FL-1:0]           beta_in,
  output logic signed [size-1:0][IL+FL-1:0] batch,
  output logic [width:0]                    num,
  output logic signed [IL+FL-1:0]           gamma,
  output logic signed [IL+FL-1:0]           beta,
  output logic                              batch_valid,
  input  logic                              batch_taken,
  output logic [1:0]                        pending
);

  localparam int DW = IL + FL;
  localparam logic [width:0] LAST_IDX = (width+1)'(size - 1);

  logic           r_wrBank;
  logic           r_rdBank;
  logic [width:0] r_cnt;

  logic                          w_accept;
  logic                          w_close;
  logic                          w_take;
  logic                          w_full    [2];
  logic signed [size-1:0][DW-1:0] w_entries [2];
  logic [width:0]                w_num     [2];
  logic signed [DW-1:0]          w_gamma   [2];
  logic signed [DW-1:0]          w_beta    [2];

  // Handshake decode. in_ready depends only on registers, so there is no
  // combinational path from in_valid back to in_ready.
  assign in_ready    = ~w_full[r_wrBank];
  assign batch_valid = w_full[r_rdBank];
  assign w_accept    = in_valid && in_ready;
  assign w_close     = w_accept && (in_last || (r_cnt == LAST_IDX));
  assign w_take      = batch_taken && batch_valid;

  // Pointer and fill-counter update. Closing a batch hands the write side to
  // the other bank; taking a batch hands the read side to the other bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrBank <= 1'b0;
      r_rdBank <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_cnt    <= '0;
          r_wrBank <= ~r_wrBank;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_take) begin
        r_rdBank <= ~r_rdBank;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic w_wrSel;
    logic w_rdSel;
    assign w_wrSel = (r_wrBank == 1'(gi));
    assign w_rdSel = (r_rdBank == 1'(gi));

    bn_gather_bank #(
      .DW    (DW),
      .size  (size),
      .width (width)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .i_wrEn     (w_accept && w_wrSel),
      .i_wrIdx    (r_cnt[width-1:0]),
      .i_wrData   (in_data),
      .i_first    (r_cnt == '0),
      .i_gamma    (gamma_in),
      .i_beta     (beta_in),
      .i_close    (w_close && w_wrSel),
      .i_closeNum (r_cnt + 1'b1),
      .i_clear    (w_take && w_rdSel),
      .o_entries  (w_entries[gi]),
      .o_num      (w_num[gi]),
      .o_gamma    (w_gamma[gi]),
      .o_beta     (w_beta[gi]),
      .o_full     (w_full[gi])
    );
  end

  // Read-side mux: everything presented comes from the read bank, so it is
  // stable for as long as that bank stays full.
  assign batch   = w_entries[r_rdBank];
  assign num     = w_num[r_rdBank];
  assign gamma   = w_gamma[r_rdBank];
  assign beta    = w_beta[r_rdBank];
  assign pending = countFull(w_full[0], w_full[1]);

endmodule

// File: tb/tb_bn_batch_gather.sv
// ---------------------------------------------------------------------------
// tb_bn_batch_gather
// Directed, table-driven bench for bn_batch_gather. Each table row drives
// one clock of stream/handshake inputs and lists the handshake outputs
// expected after that edge; hand-written sequences cover batch contents,
// async reset and the zero-pad option (BN_GATHER_ZERO_PAD_EN).
// ---------------------------------------------------------------------------
module tb_bn_batch_gather;
  import bn_pkg::*;

  logic                         clk;
  logic                         reset;
  fx_t                          in_data;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  fx_t                          gamma_in;
  fx_t                          beta_in;
  logic signed [15:0][19:0]     batchOut;
  logic [4:0]                   numOut;
  fx_t                          gammaOut;
  fx_t                          betaOut;
  logic                         batch_valid;
  logic                         batch_taken;
  logic [1:0]                   pending;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic v;
    logic l;
    logic t;
    int   id;
    logic eReady;
    logic eValid;
    int   ePend;
    int   eNum;
  } vec_t;

  vec_t vecs[$];

  bn_batch_gather dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .gamma_in    (gamma_in),
    .beta_in     (beta_in),
    .batch       (batchOut),
    .num         (numOut),
    .gamma       (gammaOut),
    .beta        (betaOut),
    .batch_valid (batch_valid),
    .batch_taken (batch_taken),
    .pending     (pending)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample value for an id: id/256 in Q4.16, so id 256 is 1.0.
  function automatic fx_t fx(input int id);
    return fx_t'(id * 256);
  endfunction

  function automatic logic [31:0] u20(input logic [19:0] x);
    return {12'b0, x};
  endfunction

  function automatic logic [31:0] elem(input int idx);
    return u20(batchOut[idx]);
  endfunction

  function automatic void addVec(input logic v, input logic l, input logic t, input int id,
                                 input logic eReady, input logic eValid, input int ePend,
                                 input int eNum);
    vec_t x;
    x.v = v; x.l = l; x.t = t; x.id = id;
    x.eReady = eReady; x.eValid = eValid; x.ePend = ePend; x.eNum = eNum;
    vecs.push_back(x);
  endfunction

  // Drive one cycle of inputs at the falling edge, then let the rising edge
  // happen and settle so outputs can be sampled away from the edge.
  task automatic applyStimulus(input logic v, input logic l, input logic t, input fx_t d);
    @(negedge clk);
    in_valid    = v;
    in_last     = l;
    batch_taken = t;
    in_data     = d;
    gamma_in    = d + 20'h00111;
    beta_in     = ~d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Apply table rows [fromIdx, toIdx) and compare the handshake outputs.
  task automatic runVecs(input int fromIdx, input int toIdx);
    for (int i = fromIdx; i < toIdx; i++) begin
      applyStimulus(vecs[i].v, vecs[i].l, vecs[i].t, vecs[i].v ? fx(vecs[i].id) : fx_t'(0));
      checkOutput($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].eReady));
      checkOutput($sformatf("v%0d batch_valid", i), 32'(batch_valid), 32'(vecs[i].eValid));
      checkOutput($sformatf("v%0d pending", i), 32'(pending), 32'(vecs[i].ePend));
      checkOutput($sformatf("v%0d num", i), 32'(numOut), 32'(vecs[i].eNum));
    end
  endtask

  initial begin
    int s1, s2, s3, s4, s5, s6;

    // Fill the whole vector table up front, grouped by scenario.
    // Basic fill: 1.0..5.0, in_last on the fifth sample.
    for (int k = 1; k <= 5; k++)
      addVec(1, k == 5, 0, 256 * k, 1, k == 5, (k == 5) ? 1 : 0, (k == 5) ? 5 : 0);
    s1 = vecs.size();
    // Take it, then 16 samples auto-close bank 1, then 3 land in bank 0.
    addVec(0, 0, 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      addVec(1, 0, 0, k, 1, k == 16, (k == 16) ? 1 : 0, (k == 16) ? 16 : 0);
    for (int k = 17; k <= 19; k++)
      addVec(1, 0, 0, k, 1, 1, 1, 16);
    s2 = vecs.size();
    // Take; bank 0 then shows its stale num 5. Close A (4), fill B (4),
    // hold sample 25 under backpressure, take A, then 25 goes in.
    addVec(0, 0, 1, 0, 1, 0, 0, 5);
    addVec(1, 1, 0, 20, 1, 1, 1, 4);
    for (int k = 21; k <= 23; k++)
      addVec(1, 0, 0, k, 1, 1, 1, 4);
    addVec(1, 1, 0, 24, 0, 1, 2, 4);
    addVec(1, 0, 0, 25, 0, 1, 2, 4);
    addVec(1, 0, 0, 25, 0, 1, 2, 4);
    addVec(1, 0, 1, 25, 1, 1, 1, 4);
    addVec(1, 0, 0, 25, 1, 1, 1, 4);
    s3 = vecs.size();
    // Fill C to 7 entries, closing it in the same cycle B is taken.
    for (int k = 26; k <= 30; k++)
      addVec(1, 0, 0, k, 1, 1, 1, 4);
    addVec(1, 1, 1, 31, 1, 1, 1, 7);
    s4 = vecs.size();
    // Take C, ignored take, single-sample batch.
    addVec(0, 0, 1, 0, 1, 0, 0, 4);
    addVec(0, 0, 1, 0, 1, 0, 0, 4);
    addVec(1, 1, 0, 40, 1, 1, 1, 1);
    s5 = vecs.size();
    addVec(0, 0, 1, 0, 1, 0, 0, 7);
    s6 = vecs.size();

    in_valid = 0; in_last = 0; batch_taken = 0;
    in_data = '0; gamma_in = '0; beta_in = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state.
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst batch_valid", 32'(batch_valid), 32'd0);
    checkOutput("rst pending", 32'(pending), 32'd0);
    checkOutput("rst num", 32'(numOut), 32'd0);
    checkOutput("rst gamma", u20(gammaOut), 32'd0);
    checkOutput("rst beta", u20(betaOut), 32'd0);
    checkOutput("rst batch0", elem(0), 32'd0);
    checkOutput("rst batch15", elem(15), 32'd0);

    runVecs(0, s1);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("basic batch%0d", k), elem(k), u20(fx(256 * (k + 1))));
    checkOutput("basic gamma", u20(gammaOut), u20(fx(256) + 20'h00111));
    checkOutput("basic beta", u20(betaOut), u20(~fx(256)));

    runVecs(s1, s2);
    checkOutput("auto batch0", elem(0), u20(fx(1)));
    checkOutput("auto batch15", elem(15), u20(fx(16)));
    checkOutput("auto gamma", u20(gammaOut), u20(fx(1) + 20'h00111));

    runVecs(s2, s3);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("bp B batch%0d", k), elem(k), u20(fx(21 + k)));
    checkOutput("bp B gamma", u20(gammaOut), u20(fx(21) + 20'h00111));

    runVecs(s3, s4);
    for (int k = 0; k < 7; k++)
      checkOutput($sformatf("sim C batch%0d", k), elem(k), u20(fx(25 + k)));
    checkOutput("sim C gamma", u20(gammaOut), u20(fx(25) + 20'h00111));
    checkOutput("sim C beta", u20(betaOut), u20(~fx(25)));

    runVecs(s4, s5);
    checkOutput("single batch0", elem(0), u20(fx(40)));
    checkOutput("single gamma", u20(gammaOut), u20(fx(40) + 20'h00111));
    runVecs(s5, s6);

    // Async reset with one batch presented and a partial one filling.
    applyStimulus(1, 1, 0, fx(41));
    checkOutput("prerst valid", 32'(batch_valid), 32'd1);
    applyStimulus(1, 0, 0, fx(42));
    applyStimulus(1, 0, 0, fx(43));
    applyStimulus(1, 0, 0, fx(44));
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("arst batch_valid", 32'(batch_valid), 32'd0);
    checkOutput("arst in_ready", 32'(in_ready), 32'd1);
    checkOutput("arst pending", 32'(pending), 32'd0);
    checkOutput("arst num", 32'(numOut), 32'd0);
    checkOutput("arst batch0", elem(0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 0, fx(45));
    applyStimulus(1, 1, 0, fx(46));
    checkOutput("postrst valid", 32'(batch_valid), 32'd1);
    checkOutput("postrst num", 32'(numOut), 32'd2);
    checkOutput("postrst batch0", elem(0), u20(fx(45)));
    checkOutput("postrst batch1", elem(1), u20(fx(46)));
    checkOutput("postrst batch2", elem(2), 32'd0);
    checkOutput("postrst gamma", u20(gammaOut), u20(fx(45) + 20'h00111));
    applyStimulus(0, 0, 1, fx_t'(0));

    // Stale-versus-zeroed entries: num=8 batch in bank 1, then num=2 in bank 1.
    for (int k = 0; k < 8; k++)
      applyStimulus(1, k == 7, 0, fx(50 + k));
    checkOutput("pad8 num", 32'(numOut), 32'd8);
    applyStimulus(0, 0, 1, fx_t'(0));
    applyStimulus(1, 1, 0, fx(60));
    checkOutput("pad single num", 32'(numOut), 32'd1);
    applyStimulus(0, 0, 1, fx_t'(0));
    applyStimulus(1, 0, 0, fx(61));
    applyStimulus(1, 1, 0, fx(62));
    checkOutput("pad2 valid", 32'(batch_valid), 32'd1);
    checkOutput("pad2 num", 32'(numOut), 32'd2);
    checkOutput("pad2 batch0", elem(0), u20(fx(61)));
    checkOutput("pad2 batch1", elem(1), u20(fx(62)));
    for (int k = 2; k < 16; k++) begin
`ifdef BN_GATHER_ZERO_PAD_EN
      checkOutput($sformatf("pad2 batch%0d", k), elem(k), 32'd0);
`else
      checkOutput($sformatf("pad2 batch%0d", k), elem(k), (k < 8) ? u20(fx(50 + k)) : 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
